// File: rtl/memory_write_split_pkg.sv
// Shared types for the write splitter: FSM state encoding.
package memory_write_split_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StProbe,
        StFirst,
        StSecond
    } state_t;

endpackage

// File: rtl/memory_write_split_calc.sv
// Combinational line-crossing split: sizes, address and shifted data of the second piece.
module memory_write_split_calc #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned LINE_LOG2  = 4,
    localparam int unsigned LW = $clog2(DATA_BYTES + 1)
) (
    input  logic [31:0]             address,
    input  logic [LW-1:0]           length,
    input  logic [8*DATA_BYTES-1:0] data,
    output logic [LW-1:0]           len1,
    output logic [LW-1:0]           len2,
    output logic [31:0]             addr2,
    output logic [8*DATA_BYTES-1:0] data2
);

    localparam int unsigned CW = LINE_LOG2 + 1;
    localparam int unsigned TW = 32 - LINE_LOG2;

    logic [CW-1:0] left;
    logic [TW-1:0] line_next;

    // Bytes remaining up to the end of the current line, 1..2**LINE_LOG2.
    assign left      = {1'b1, {LINE_LOG2{1'b0}}} - {1'b0, address[LINE_LOG2-1:0]};
    assign line_next = address[31:LINE_LOG2] + TW'(1);

    always_comb begin
        len1 = length;
        if (left < CW'(length)) begin
            len1 = LW'(left);
        end
    end

    assign len2  = length - len1;
    assign addr2 = {line_next, {LINE_LOG2{1'b0}}};
    assign data2 = data >> {len1, 3'b000};

endmodule

// File: rtl/memory_write_split.sv
// Splits a line-crossing write into up to two TLB writes, optionally probing the second
// page first so a fault there aborts the write before any byte is stored.
module memory_write_split
    import memory_write_split_pkg::*;
#(
    parameter int unsigned DATA_BYTES   = 4,
    parameter int unsigned LINE_LOG2    = 4,
    parameter int unsigned PROBE_SECOND = 1,
    localparam int unsigned LW = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_reset,
    input  logic                    write_do,
    output logic                    write_done,
    output logic                    write_page_fault,
    output logic                    write_ac_fault,
    input  logic [1:0]              write_cpl,
    input  logic [31:0]             write_address,
    input  logic [LW-1:0]           write_length,
    input  logic                    write_lock,
    input  logic                    write_rmw,
    input  logic [8*DATA_BYTES-1:0] write_data,
    output logic                    tlbwrite_do,
    output logic                    tlbwrite_probe,
    input  logic                    tlbwrite_done,
    input  logic                    tlbwrite_page_fault,
    input  logic                    tlbwrite_ac_fault,
    output logic [1:0]              tlbwrite_cpl,
    output logic                    tlbwrite_lock,
    output logic                    tlbwrite_rmw,
    output logic [LW-1:0]           tlbwrite_length_full,
    output logic [31:0]             tlbwrite_address,
    output logic [LW-1:0]           tlbwrite_length,
    output logic [8*DATA_BYTES-1:0] tlbwrite_data
);

    state_t                  state;
    logic                    reset_waiting;
    logic                    page_fault_q;
    logic                    ac_fault_q;
    logic [LW-1:0]           len2_q;
    logic [31:0]             addr2_q;
    logic [8*DATA_BYTES-1:0] data2_q;

    logic [LW-1:0]           len1;
    logic [LW-1:0]           len2;
    logic [31:0]             addr2;
    logic [8*DATA_BYTES-1:0] data2;
    logic                    tlb_fault;
    logic                    accept;
    logic                    probe_first;

    memory_write_split_calc #(
        .DATA_BYTES(DATA_BYTES),
        .LINE_LOG2 (LINE_LOG2)
    ) u_calc (
        .address(write_address),
        .length (write_length),
        .data   (write_data),
        .len1   (len1),
        .len2   (len2),
        .addr2  (addr2),
        .data2  (data2)
    );

    assign write_page_fault = page_fault_q | tlbwrite_page_fault;
    assign write_ac_fault   = ac_fault_q | tlbwrite_ac_fault;

    assign tlb_fault   = tlbwrite_page_fault | tlbwrite_ac_fault;
    assign accept      = write_do & ~wr_reset & ~write_page_fault & ~write_ac_fault;
    assign probe_first = (PROBE_SECOND != 0) && (len2 != '0);

    assign tlbwrite_cpl         = write_cpl;
    assign tlbwrite_lock        = write_lock;
    assign tlbwrite_rmw         = write_rmw;
    assign tlbwrite_length_full = write_length;

    always_comb begin
        tlbwrite_do      = 1'b0;
        tlbwrite_probe   = 1'b0;
        tlbwrite_address = write_address;
        tlbwrite_length  = len1;
        tlbwrite_data    = write_data;
        write_done       = 1'b0;
        unique case (state)
            StIdle: begin
                if (accept) begin
                    tlbwrite_do = 1'b1;
                    // Probe fields go out already in the acceptance cycle.
                    if (probe_first) begin
                        tlbwrite_probe   = 1'b1;
                        tlbwrite_address = addr2;
                        tlbwrite_length  = len2;
                        tlbwrite_data    = '0;
                    end
                end
            end
            StProbe: begin
                tlbwrite_do      = 1'b1;
                tlbwrite_probe   = 1'b1;
                tlbwrite_address = addr2_q;
                tlbwrite_length  = len2_q;
                tlbwrite_data    = '0;
            end
            StFirst: begin
                tlbwrite_do = 1'b1;
                write_done  = tlbwrite_done & ~tlb_fault & (len2_q == '0) & ~reset_waiting;
            end
            StSecond: begin
                tlbwrite_do      = 1'b1;
                tlbwrite_address = addr2_q;
                tlbwrite_length  = len2_q;
                tlbwrite_data    = data2_q;
                write_done       = tlbwrite_done & ~tlb_fault & ~reset_waiting;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            reset_waiting <= 1'b0;
            page_fault_q  <= 1'b0;
            ac_fault_q    <= 1'b0;
            len2_q        <= '0;
            addr2_q       <= '0;
            data2_q       <= '0;
        end else begin
            if (state == StIdle) begin
                reset_waiting <= 1'b0;
                len2_q        <= len2;
                addr2_q       <= addr2;
                data2_q       <= data2;
            end else if (wr_reset) begin
                reset_waiting <= 1'b1;
            end

            if (wr_reset) begin
                page_fault_q <= 1'b0;
                ac_fault_q   <= 1'b0;
            end else if (!reset_waiting) begin
                if (tlbwrite_page_fault) page_fault_q <= 1'b1;
                if (tlbwrite_ac_fault)   ac_fault_q   <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (accept) state <= probe_first ? StProbe : StFirst;
                end
                StProbe: begin
                    if (tlb_fault)          state <= StIdle;
                    else if (tlbwrite_done) state <= StFirst;
                end
                StFirst: begin
                    if (tlb_fault)          state <= StIdle;
                    else if (tlbwrite_done) state <= (len2_q != '0) ? StSecond : StIdle;
                end
                StSecond: begin
                    if (tlb_fault || tlbwrite_done) state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_write_split.sv
// Bench for memory_write_split: a 4-byte legacy-order instance and an 8-byte probing instance.
module tb_memory_write_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        wr_reset[2], write_do[2], write_lock[2], write_rmw[2];
    logic [1:0]  write_cpl[2];
    logic [31:0] write_address[2];
    logic [3:0]  write_length[2];
    logic [63:0] write_data[2];
    logic        write_done[2], wpf[2], wac[2], tdo[2], tprobe[2], tlock[2], trmw[2];
    logic [1:0]  tcpl[2];
    logic [31:0] taddr[2];
    logic        tdone[2], tpf[2], tac[2];

    logic [2:0]  tlen4, tlenf4;
    logic [3:0]  tlen8, tlenf8;
    logic [31:0] tdata4;
    logic [63:0] tdata8;
    logic [3:0]  tlen[2], tlenf[2];
    logic [63:0] tdata[2];

    assign tlen[0]  = {1'b0, tlen4};
    assign tlen[1]  = tlen8;
    assign tlenf[0] = {1'b0, tlenf4};
    assign tlenf[1] = tlenf8;
    assign tdata[0] = {32'h0, tdata4};
    assign tdata[1] = tdata8;

    memory_write_split #(.DATA_BYTES(4), .LINE_LOG2(4), .PROBE_SECOND(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wr_reset(wr_reset[0]), .write_do(write_do[0]),
        .write_done(write_done[0]), .write_page_fault(wpf[0]), .write_ac_fault(wac[0]),
        .write_cpl(write_cpl[0]), .write_address(write_address[0]),
        .write_length(write_length[0][2:0]), .write_lock(write_lock[0]),
        .write_rmw(write_rmw[0]), .write_data(write_data[0][31:0]),
        .tlbwrite_do(tdo[0]), .tlbwrite_probe(tprobe[0]), .tlbwrite_done(tdone[0]),
        .tlbwrite_page_fault(tpf[0]), .tlbwrite_ac_fault(tac[0]), .tlbwrite_cpl(tcpl[0]),
        .tlbwrite_lock(tlock[0]), .tlbwrite_rmw(trmw[0]), .tlbwrite_length_full(tlenf4),
        .tlbwrite_address(taddr[0]), .tlbwrite_length(tlen4), .tlbwrite_data(tdata4)
    );

    memory_write_split #(.DATA_BYTES(8), .LINE_LOG2(4), .PROBE_SECOND(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .wr_reset(wr_reset[1]), .write_do(write_do[1]),
        .write_done(write_done[1]), .write_page_fault(wpf[1]), .write_ac_fault(wac[1]),
        .write_cpl(write_cpl[1]), .write_address(write_address[1]),
        .write_length(write_length[1]), .write_lock(write_lock[1]),
        .write_rmw(write_rmw[1]), .write_data(write_data[1]),
        .tlbwrite_do(tdo[1]), .tlbwrite_probe(tprobe[1]), .tlbwrite_done(tdone[1]),
        .tlbwrite_page_fault(tpf[1]), .tlbwrite_ac_fault(tac[1]), .tlbwrite_cpl(tcpl[1]),
        .tlbwrite_lock(tlock[1]), .tlbwrite_rmw(trmw[1]), .tlbwrite_length_full(tlenf8),
        .tlbwrite_address(taddr[1]), .tlbwrite_length(tlen8), .tlbwrite_data(tdata8)
    );

    typedef struct {
        logic        probe;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  lenf;
        logic [63:0] data;
    } txn_t;

    typedef struct {
        int           k;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [63:0]  data;
        int           lat;
        int           n;
        logic [2:0]   p;
        logic [95:0]  a;
        logic [11:0]  l;
        logic [191:0] d;
    } vec_t;

    txn_t tlog[2][4];
    int   nlog[2], ndone[2], done_cyc[2], tdo_cnt[2], ntx[2], fault_at[2], fault_kind[2], age[2];
    logic saw_fault[2];
    int   cyc, npass, ntotal;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock: sample at negedge, then apply the TLB model's response just after posedge.
    // The model answers each request on its third cycle; fault_kind 0=page, 1=ac, 2=page+done.
    task automatic tick();
        logic raise[2];
        logic drop[2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            raise[k] = 1'b0;
            drop[k]  = 1'b0;
            if (write_done[k]) begin
                ndone[k]++;
                done_cyc[k] = cyc;
            end
            if (wpf[k] || wac[k]) saw_fault[k] = 1'b1;
            if (tdo[k]) tdo_cnt[k]++;
            if (tdone[k] || tpf[k] || tac[k]) begin
                if (nlog[k] < 4) tlog[k][nlog[k]] = '{tprobe[k], taddr[k], tlen[k], tlenf[k], tdata[k]};
                nlog[k]++;
                drop[k] = 1'b1;
                age[k]  = 0;
            end else if (tdo[k]) begin
                age[k]++;
                raise[k] = (age[k] == 2);
            end else begin
                age[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (drop[k]) begin
                tdone[k] = 1'b0;
                tpf[k]   = 1'b0;
                tac[k]   = 1'b0;
            end
            if (raise[k]) begin
                if (ntx[k] == fault_at[k]) begin
                    tpf[k]   = (fault_kind[k] != 1);
                    tac[k]   = (fault_kind[k] == 1);
                    tdone[k] = (fault_kind[k] == 2);
                end else begin
                    tdone[k] = 1'b1;
                end
                ntx[k]++;
            end
        end
    endtask

    task automatic run_write(input int k, input logic [31:0] a, input logic [3:0] l,
                             input logic [63:0] d, output int lat);
        int start, d0, budget;
        write_address[k] = a;
        write_length[k]  = l;
        write_data[k]    = d;
        d0           = ndone[k];
        saw_fault[k] = 1'b0;
        start        = cyc;
        budget       = 0;
        write_do[k]  = 1'b1;
        while (ndone[k] == d0 && !saw_fault[k] && budget < 40) begin
            tick();
            budget++;
        end
        write_do[k] = 1'b0;
        if (budget >= 40) begin
            ntotal++;
            $display("FAIL bound: write at %h on dut%0d got no done/fault, required one", a, k);
        end
        lat = (ndone[k] != d0) ? done_cyc[k] - start : -1;
    endtask

    function automatic vec_t mkv(input int k, input logic [31:0] addr, input logic [3:0] len,
                                 input logic [63:0] data, input int lat, input int n,
                                 input logic [2:0] p, input logic [95:0] a,
                                 input logic [11:0] l, input logic [191:0] d);
        vec_t v;
        v.k = k; v.addr = addr; v.len = len; v.data = data; v.lat = lat; v.n = n;
        v.p = p; v.a = a; v.l = l; v.d = d;
        return v;
    endfunction

    vec_t vecs[9];

    initial begin
        int lat, d0, b;
        cyc = 0; npass = 0; ntotal = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_reset[k] = 1'b0; write_do[k] = 1'b0; write_lock[k] = 1'b1; write_rmw[k] = 1'b0;
            write_cpl[k] = 2'b10; write_address[k] = '0; write_length[k] = '0;
            write_data[k] = '0; tdone[k] = 1'b0; tpf[k] = 1'b0; tac[k] = 1'b0;
            nlog[k] = 0; ndone[k] = 0; done_cyc[k] = 0; tdo_cnt[k] = 0; ntx[k] = 0;
            fault_at[k] = -1; fault_kind[k] = 0; age[k] = 0; saw_fault[k] = 1'b0;
        end

        // Piece order: entry 0 in the low slice of a/l/d.
        vecs[0] = mkv(0, 32'h1000, 4, 64'hDDCCBBAA, 2, 1, 3'b000,
                      {32'h0, 32'h0, 32'h1000}, {4'd0, 4'd0, 4'd4},
                      {64'h0, 64'h0, 64'hDDCCBBAA});
        vecs[1] = mkv(0, 32'h100E, 4, 64'hDDCCBBAA, 5, 2, 3'b000,
                      {32'h0, 32'h1010, 32'h100E}, {4'd0, 4'd2, 4'd2},
                      {64'h0, 64'h0000DDCC, 64'hDDCCBBAA});
        vecs[2] = mkv(0, 32'hFFFFFFFE, 4, 64'h44332211, 5, 2, 3'b000,
                      {32'h0, 32'h0, 32'hFFFFFFFE}, {4'd0, 4'd2, 4'd2},
                      {64'h0, 64'h00004433, 64'h44332211});
        vecs[3] = mkv(0, 32'h100F, 1, 64'hEE, 2, 1, 3'b000,
                      {32'h0, 32'h0, 32'h100F}, {4'd0, 4'd0, 4'd1},
                      {64'h0, 64'h0, 64'hEE});
        vecs[4] = mkv(0, 32'h100D, 4, 64'h44332211, 5, 2, 3'b000,
                      {32'h0, 32'h1010, 32'h100D}, {4'd0, 4'd1, 4'd3},
                      {64'h0, 64'h44, 64'h44332211});
        vecs[5] = mkv(1, 32'h2FFD, 8, 64'h8877665544332211, 8, 3, 3'b001,
                      {32'h3000, 32'h2FFD, 32'h3000}, {4'd5, 4'd3, 4'd5},
                      {64'h0000008877665544, 64'h8877665544332211, 64'h0});
        vecs[6] = mkv(1, 32'h2000, 8, 64'h1122334455667788, 2, 1, 3'b000,
                      {32'h0, 32'h0, 32'h2000}, {4'd0, 4'd0, 4'd8},
                      {64'h0, 64'h0, 64'h1122334455667788});
        vecs[7] = mkv(1, 32'h2FF8, 4, 64'hAABBCCDD, 2, 1, 3'b000,
                      {32'h0, 32'h0, 32'h2FF8}, {4'd0, 4'd0, 4'd4},
                      {64'h0, 64'h0, 64'hAABBCCDD});
        vecs[8] = mkv(1, 32'h2FFE, 3, 64'hCCBBAA, 8, 3, 3'b001,
                      {32'h3000, 32'h2FFE, 32'h3000}, {4'd1, 4'd2, 4'd1},
                      {64'hCC, 64'hCCBBAA, 64'h0});

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset dut%0d tlbwrite_do", k), 64'(tdo[k]), 64'h0);
            check($sformatf("reset dut%0d tlbwrite_probe", k), 64'(tprobe[k]), 64'h0);
            check($sformatf("reset dut%0d write_done", k), 64'(write_done[k]), 64'h0);
            check($sformatf("reset dut%0d page_fault", k), 64'(wpf[k]), 64'h0);
            check($sformatf("reset dut%0d ac_fault", k), 64'(wac[k]), 64'h0);
        end
        rst_n = 1'b1;
        tick();
        tick();

        check("cpl passthrough", 64'(tcpl[1]), 64'h2);
        check("lock passthrough", 64'(tlock[0]), 64'h1);
        check("rmw passthrough", 64'(trmw[1]), 64'h0);

        for (int i = 0; i < 9; i++) begin
            int k;
            k = vecs[i].k;
            nlog[k] = 0;
            run_write(k, vecs[i].addr, vecs[i].len, vecs[i].data, lat);
            tick();
            check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d transactions", i), 64'(nlog[k]), 64'(vecs[i].n));
            for (int j = 0; j < vecs[i].n && j < 4; j++) begin
                check($sformatf("v%0d.%0d probe", i, j), 64'(tlog[k][j].probe), 64'(vecs[i].p[j]));
                check($sformatf("v%0d.%0d addr", i, j), 64'(tlog[k][j].addr),
                      64'(vecs[i].a[32*j +: 32]));
                check($sformatf("v%0d.%0d len", i, j), 64'(tlog[k][j].len),
                      64'(vecs[i].l[4*j +: 4]));
                check($sformatf("v%0d.%0d len_full", i, j), 64'(tlog[k][j].lenf),
                      64'(vecs[i].len));
                check($sformatf("v%0d.%0d data", i, j), tlog[k][j].data, vecs[i].d[64*j +: 64]);
            end
        end

        // Probe answered with page fault and done together: nothing stored, fault sticky.
        nlog[1] = 0; d0 = ndone[1]; fault_at[1] = ntx[1]; fault_kind[1] = 2;
        run_write(1, 32'h2FFD, 8, 64'h8877665544332211, lat);
        check("probe fault seen", 64'(saw_fault[1]), 64'h1);
        repeat (3) tick();
        check("probe fault sticky", 64'(wpf[1]), 64'h1);
        tdo_cnt[1] = 0;
        write_do[1] = 1'b1;
        repeat (4) tick();
        write_do[1] = 1'b0;
        check("write_do blocked by fault", 64'(tdo_cnt[1]), 64'h0);
        check("probe fault transactions", 64'(nlog[1]), 64'h1);
        check("probe fault was probe", 64'(tlog[1][0].probe), 64'h1);
        check("probe fault no done", 64'(ndone[1] - d0), 64'h0);
        wr_reset[1] = 1'b1;
        tick();
        wr_reset[1] = 1'b0;
        check("probe fault cleared", 64'(wpf[1]), 64'h0);
        fault_at[1] = -1;

        // Legacy order, ac fault on the second piece.
        nlog[0] = 0; d0 = ndone[0]; fault_at[0] = ntx[0] + 1; fault_kind[0] = 1;
        run_write(0, 32'h100E, 4, 64'hDDCCBBAA, lat);
        repeat (2) tick();
        check("ac fault transactions", 64'(nlog[0]), 64'h2);
        check("ac fault sticky", 64'(wac[0]), 64'h1);
        check("ac fault no done", 64'(ndone[0] - d0), 64'h0);
        wr_reset[0] = 1'b1;
        tick();
        wr_reset[0] = 1'b0;
        check("ac fault cleared", 64'(wac[0]), 64'h0);
        fault_at[0] = -1;

        // Flush during FIRST of a split write: both pieces complete, write_done suppressed.
        nlog[0] = 0; d0 = ndone[0];
        write_address[0] = 32'h100E; write_length[0] = 4; write_data[0] = 64'hDDCCBBAA;
        write_do[0] = 1'b1;
        tick();
        wr_reset[0] = 1'b1;
        write_do[0] = 1'b0;
        tick();
        wr_reset[0] = 1'b0;
        b = 0;
        while (nlog[0] < 2 && b < 40) begin
            tick();
            b++;
        end
        repeat (2) tick();
        check("flush transactions", 64'(nlog[0]), 64'h2);
        check("flush second addr", 64'(tlog[0][1].addr), 64'h1010);
        check("flush no done", 64'(ndone[0] - d0), 64'h0);
        run_write(0, 32'h1000, 4, 64'h11223344, lat);
        check("after flush latency", 64'(lat), 64'h2);

        // wr_reset in the acceptance cycle blocks acceptance.
        tdo_cnt[0] = 0;
        write_do[0] = 1'b1;
        wr_reset[0] = 1'b1;
        tick();
        write_do[0] = 1'b0;
        wr_reset[0] = 1'b0;
        repeat (3) tick();
        check("reset blocks accept", 64'(tdo_cnt[0]), 64'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
